// File: rtl/nonogram_pkg.sv
// Shared nonogram solver types and constants: option word format, queue state
// encoding and puzzle size limits.
package nonogram_pkg;

  localparam int OPT_WIDTH       = 16;
  localparam int MAX_ROWS        = 22;
  localparam int MAX_COLS        = 22;
  localparam int MAX_NUM_OPTIONS = 84;

  typedef logic [15:0] opt_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    SOLVE = 2'd3
  } q_state_t;

endpackage

// File: rtl/option_queue_circ_buffer.sv
// Circular buffer of DEPTH words with registered full/empty and a
// combinational head read; clr_i rewinds pointers and count.
module circ_buffer
  import nonogram_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int WIDTH = OPT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage carries no reset; a write on a full+pop cycle lands at the old wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = mem[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = full_q;
  assign empty_o      = empty_q;

endmodule

// File: rtl/option_queue.sv
// Option queue feeding the line solver: load/start/solve control around a
// circular buffer. Optional peak-occupancy output via OPTION_QUEUE_WATERMARK_EN.
module option_queue
  import nonogram_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int WIDTH = OPT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [WIDTH-1:0]       load_data,
  input  logic                   load_done,
  input  logic                   solve_end,
  input  logic                   pop,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       option,
  output logic                   option_valid,
  output logic                   started,
`ifdef OPTION_QUEUE_WATERMARK_EN
  output logic [$clog2(DEPTH):0] peak_count,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  q_state_t         state_q, state_d;
  logic             started_q, started_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             clr, wr_en, rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [CW-1:0]    count_next;

  circ_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .rd_en_i      (rd_en),
    .rd_data_o    (option),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    state_d     = state_q;
    started_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    clr         = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_data     = load_data;
    if (load_start) begin
      state_d     = LOAD;
      clr         = 1'b1;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (load_valid) begin
            if (!full) wr_en = 1'b1;
            else       overflow_d = 1'b1;
          end
          if (load_done) state_d = START;
        end
        START: begin
          started_d = 1'b1;
          state_d   = SOLVE;
        end
        SOLVE: begin
          if (solve_end) begin
            state_d = IDLE;
          end else begin
            rd_en = pop && !empty;
            if (pop && empty) underflow_d = 1'b1;
            // A pop in the same cycle frees the slot, so a full queue still accepts.
            if (push) begin
              wr_data = push_data;
              if (!full || rd_en) wr_en = 1'b1;
              else                overflow_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      started_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef OPTION_QUEUE_WATERMARK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clr)                        peak_d = '0;
    else if (count_next > peak_q)   peak_d = count_next;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

  assign option_valid = (state_q == SOLVE) && !empty;
  assign started      = started_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_option_queue.sv
// Directed bench for option_queue (DEPTH=8); peak_count checks are compiled in
// when OPTION_QUEUE_WATERMARK_EN is defined.
module tb_option_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst, load_start, load_valid, load_done, solve_end, pop, push;
  logic [WIDTH-1:0] load_data, push_data, option;
  logic             option_valid, started, full, empty, overflow, underflow;
  logic [CW-1:0]    count;
`ifdef OPTION_QUEUE_WATERMARK_EN
  logic [CW-1:0]    peak_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  option_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_done    (load_done),
    .solve_end    (solve_end),
    .pop          (pop),
    .push         (push),
    .push_data    (push_data),
    .option       (option),
    .option_valid (option_valid),
    .started      (started),
`ifdef OPTION_QUEUE_WATERMARK_EN
    .peak_count   (peak_count),
`endif
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Loads n words base+i (or the 4-word table), pulses load_done, then steps into SOLVE.
  task automatic load_words(input int n, input logic [15:0] base, input bit use_tbl);
    logic [15:0] tbl [4];
    tbl[0] = 16'h0003; tbl[1] = 16'h00A5; tbl[2] = 16'h005A; tbl[3] = 16'h00FF;
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = use_tbl ? tbl[i] : base + 16'(i);
      cycle();
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    cycle();
    load_done  = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_tests++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_tests++; if ({started, overflow, underflow, option_valid} !== 4'b0)
      begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {started, overflow, underflow, option_valid}); end
  endtask

  task automatic test_load_start_pulse();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 0) ? 16'h0003 : (i == 1) ? 16'h00A5 : (i == 2) ? 16'h005A : 16'h00FF;
      cycle();
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    cycle();
    load_done  = 1'b0;
    n_tests++; if (started !== 1'b0) begin n_fail++; $display("FAIL started_early got %b exp 0", started); end
    cycle();
    n_tests++; if (started !== 1'b1) begin n_fail++; $display("FAIL started_pulse got %b exp 1", started); end
    n_tests++; if (count !== 4'd4)   begin n_fail++; $display("FAIL load_count got %0d exp 4", count); end
    n_tests++; if (option !== 16'h0003) begin n_fail++; $display("FAIL load_head got %h exp 0003", option); end
    n_tests++; if (option_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid_out got %b exp 1", option_valid); end
    cycle();
    n_tests++; if (started !== 1'b0) begin n_fail++; $display("FAIL started_one_cycle got %b exp 0", started); end
  endtask

  task automatic test_pop_sequence();
    logic [15:0] exp [4];
    exp[0] = 16'h0003; exp[1] = 16'h00A5; exp[2] = 16'h005A; exp[3] = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (option !== exp[i]) begin n_fail++; $display("FAIL pop_seq[%0d] got %h exp %h", i, option, exp[i]); end
      pop = 1'b1;
      cycle();
      pop = 1'b0;
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty got %b exp 1", empty); end
    n_tests++; if (option_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid got %b exp 0", option_valid); end
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_early got %b exp 0", underflow); end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow got %b exp 1", underflow); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL underflow_count got %0d exp 0", count); end
  endtask

  task automatic test_overflow_wrap();
    load_words(9, 16'h0010, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL load_overflow got %b exp 1", overflow); end
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL load_overflow_count got %0d exp 8", count); end
    load_words(8, 16'h0010, 1'b0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_cleared got %b exp 0", overflow); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full got %b exp 1", full); end
    push = 1'b1; push_data = 16'h1234;
    cycle();
    push = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL push_overflow got %b exp 1", overflow); end
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL push_overflow_count got %0d exp 8", count); end
    n_tests++; if (option !== 16'h0010) begin n_fail++; $display("FAIL dropped_push_head got %h exp 0010", option); end
    pop = 1'b1; push = 1'b1; push_data = 16'h1234;
    cycle();
    pop = 1'b0; push = 1'b0;
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_popush_count got %0d exp 8", count); end
    for (int i = 1; i < 8; i++) begin
      n_tests++; if (option !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL wrap_seq[%0d] got %h exp %h", i, option, 16'h0010 + 16'(i)); end
      pop = 1'b1;
      cycle();
      pop = 1'b0;
    end
    n_tests++; if (option !== 16'h1234) begin n_fail++; $display("FAIL wrap_word got %h exp 1234", option); end
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL wrap_count got %0d exp 1", count); end
  endtask

  task automatic test_requeue();
    logic [15:0] q [$];
    logic [15:0] h;
    q = '{16'h0001, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = q[i];
      cycle();
    end
    load_valid = 1'b0; load_done = 1'b1;
    cycle();
    load_done = 1'b0;
    cycle();
    for (int c = 0; c < 20; c++) begin
      h = q.pop_front();
      n_tests++; if (option !== h) begin n_fail++; $display("FAIL requeue_head[%0d] got %h exp %h", c, option, h); end
      pop = 1'b1; push = 1'b1; push_data = h;
      q.push_back(h);
      cycle();
      pop = 1'b0; push = 1'b0;
    end
    n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL requeue_count got %0d exp 5", count); end
    n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL requeue_flags got %b exp 00", {overflow, underflow}); end
    n_tests++; if (option !== 16'h0001) begin n_fail++; $display("FAIL requeue_final got %h exp 0001", option); end
  endtask

  task automatic test_restart();
    load_words(9, 16'h0040, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pop = 1'b1;
      cycle();
    end
    pop = 1'b0;
    n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL restart_pre_count got %0d exp 3", count); end
    load_start = 1'b1; solve_end = 1'b1;
    cycle();
    load_start = 1'b0; solve_end = 1'b0;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL restart_count got %0d exp 0", count); end
    n_tests++; if ({overflow, underflow, empty, option_valid} !== 4'b0010)
      begin n_fail++; $display("FAIL restart_flags got %b exp 0010", {overflow, underflow, empty, option_valid}); end
    load_valid = 1'b1; load_data = 16'hBEEF; load_done = 1'b1;
    cycle();
    load_valid = 1'b0; load_done = 1'b0;
    cycle();
    n_tests++; if (option !== 16'hBEEF || option_valid !== 1'b1)
      begin n_fail++; $display("FAIL restart_reload got %h/%b exp beef/1", option, option_valid); end
    n_tests++; if (started !== 1'b1) begin n_fail++; $display("FAIL restart_started got %b exp 1", started); end
    solve_end = 1'b1; pop = 1'b1;
    cycle();
    solve_end = 1'b0; pop = 1'b0;
    n_tests++; if (option_valid !== 1'b0 || count !== 4'd1)
      begin n_fail++; $display("FAIL solve_end got valid=%b count=%0d exp 0/1", option_valid, count); end
  endtask

`ifdef OPTION_QUEUE_WATERMARK_EN
  task automatic test_watermark();
    load_words(6, 16'h0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      cycle();
    end
    pop = 1'b0; push = 1'b1; push_data = 16'h0777;
    cycle();
    push = 1'b0;
    n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL wm_count got %0d exp 3", count); end
    n_tests++; if (peak_count !== 4'd6) begin n_fail++; $display("FAIL wm_peak got %0d exp 6", peak_count); end
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    n_tests++; if (peak_count !== 4'd0) begin n_fail++; $display("FAIL wm_clear got %0d exp 0", peak_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_done = 1'b0;
    solve_end = 1'b0; pop = 1'b0; push = 1'b0; push_data = '0;
    test_reset();
    test_load_start_pulse();
    test_pop_sequence();
    test_overflow_wrap();
    test_requeue();
    test_restart();
`ifdef OPTION_QUEUE_WATERMARK_EN
    test_watermark();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/option_queue.md
Name: option_queue

Overview:
- Circular word queue directly upstream of the line solver.
- Holds the puzzle's line stream: each header word (line index) is followed by that line's candidate option bitmasks, as loaded by the board parser.
- During solving it presents the head word to the solver, pops on the solver's advance request, and re-appends surviving words the solver writes back.
- Issues the solver's start pulse once loading completes.

Parameters:
- DEPTH, 2048, word capacity; power of two, at least 22 headers plus 22×84 options.
- WIDTH, 16, word width; matches the solver option/new_option width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- load_start  in  1  pulse: begin loading a new puzzle; clears queue
- load_valid  in  1  load_data valid this cycle
- load_data  in  WIDTH  parser word (header or option)
- load_done  in  1  pulse: parser finished
- solve_end  in  1  solver solved or unsolvable; return to idle
- pop  in  1  solver new_line: consume head word
- push  in  1  solver put_back_to_FIFO: append push_data
- push_data  in  WIDTH  solver new_option
- option  out  WIDTH  head word = mem[rd_ptr]; combinational read
- option_valid  out  1  queue non-empty and state SOLVE
- started  out  1  one-cycle pulse to solver
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: pop attempted while empty in SOLVE

Behaviour:
- Reset:
  - state=IDLE; rd_ptr=wr_ptr=0; count=0.
  - started=0, overflow=0, underflow=0, empty=1, full=0.
  - option may be X-free garbage; option_valid=0.
- Storage: DEPTH×WIDTH array. rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is one bit wider.
- States:
  - IDLE: load_start -> LOAD. Pointers, count and sticky flags are cleared on that cycle. All other inputs ignored.
  - LOAD: load_valid writes load_data at wr_ptr if not full, otherwise overflow<=1 and the word is dropped. load_done -> START. load_valid coincident with load_done is still written. pop and push are ignored.
  - START: one cycle; started<=1 registered, so it is high during the first SOLVE cycle only. -> SOLVE.
  - SOLVE:
    - pop && !empty: rd_ptr++.
    - pop && empty: underflow<=1, no pointer change.
    - push: write push_data at wr_ptr, wr_ptr++. If full and no simultaneous pop, the write is dropped and overflow<=1.
    - Simultaneous pop and push: both take effect and count is unchanged. This is legal even when full, because the pop frees the slot in the same cycle and the write lands at the old wr_ptr.
    - Pushing when empty with no pop: word becomes head next cycle.
    - solve_end -> IDLE. Pending pop/push on that cycle are discarded.
- Any state, load_start: restart LOAD with cleared queue (mid-solve restart). load_start takes priority over solve_end.
- rst mid-operation: full reset to IDLE; contents don't-care.
- Latency: a pop updates option on the next cycle. A pushed word is readable as head after one cycle if the queue was empty.
- count update: count + (push accepted) − (pop accepted). full and empty are registered from next count.

Optional Feature:
- Macro OPTION_QUEUE_WATERMARK_EN.
- Defined:
  - Extra output peak_count, $clog2(DEPTH)+1 wide, holding the maximum count seen since the last load_start.
  - Clears to 0 on rst and on load_start.
  - Updates each cycle to max(peak_count, next count).
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Shared package nonogram_pkg:
  - WIDTH default.
  - typedef opt_word_t (logic [15:0]).
  - Queue state enum q_state_t {IDLE, LOAD, START, SOLVE}.
  - MAX_ROWS, MAX_COLS, MAX_NUM_OPTIONS constants used by the solver.
- One natural sub-module: circ_buffer, holding the array, pointers, count, full and empty with write/read enables. option_queue wraps it with the state machine and handshake gating.

Test Plan:
- Load [0x0003, 0x00A5, 0x005A, 0x00FF], load_done -> started high exactly one cycle; count=4; option=0x0003; option_valid=1.
- From that state pop 4 times -> option sequence 0x0003, 0x00A5, 0x005A, 0x00FF; empty=1 after the 4th pop; an extra pop sets underflow=1.
- DEPTH=8: load 8 words, then push 0x1234 alone -> overflow=1 and count=8. Then pop+push 0x1234 in the same cycle -> count stays 8; 0x1234 emerges after 7 more pops, proving wrap-around.
- Interleaved requeue: pop header 0x0001 and push 0x0001 same cycle, repeated for 20 cycles on a 5-word queue -> content rotates; count constant at 5; no flags set.
- Mid-solve load_start with count=3 -> next cycle state LOAD, count=0, flags cleared. solve_end asserted together with load_start is ignored.
- With OPTION_QUEUE_WATERMARK_EN: load 6 words, pop 4, push 1 -> peak_count=6. After load_start -> peak_count=0.
